// File: rtl/ts_pkg.sv
// ts_pkg: word codes, queue indices, FSM encoding and priority pick shared by the TS scheduler
package ts_pkg;

    localparam int TS_DATA_W = 134;

    localparam logic [1:0] CODE_HEAD = 2'b01;
    localparam logic [1:0] CODE_MID  = 2'b11;
    localparam logic [1:0] CODE_TAIL = 2'b10;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    // strict priority: the lowest set eligibility bit wins
    function automatic logic [1:0] prio_sel(input logic [3:0] v);
        return v[0] ? Q0 : v[1] ? Q1 : v[2] ? Q2 : Q3;
    endfunction

endpackage

// File: rtl/ts_out_pipe.sv
// ts_out_pipe: two-stage output register whose second stage applies a per-packet drop gate
module ts_out_pipe
    import ts_pkg::*;
#(
    parameter int DATA_W = TS_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] word,
    input  logic              wr,
    input  logic              sop,
    input  logic              discard,
    output logic [DATA_W-1:0] data,
    output logic              data_wr
);

    logic [DATA_W-1:0] s1_word;
    logic              s1_wr;
    logic              s1_sop;
    logic              drop;
    logic              kill;

    // the drop decision lands while the head word sits in stage 1, so it is taken
    // there and then held for the rest of the packet until the next head arrives
    assign kill = s1_sop ? discard : drop;

    // stage 1 captures the popped word, stage 2 forwards it unless the packet is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_word <= '0;
            s1_wr   <= 1'b0;
            s1_sop  <= 1'b0;
            drop    <= 1'b0;
            data    <= '0;
            data_wr <= 1'b0;
        end else begin
            s1_word <= word;
            s1_wr   <= wr;
            s1_sop  <= sop & wr;
            drop    <= kill;
            data    <= s1_word;
            data_wr <= s1_wr & ~kill;
        end
    end

endmodule

// File: rtl/ts_queue_sched.sv
// ts_queue_sched: strict-priority packet scheduler draining one of four queue FIFOs onto a single bus
module ts_queue_sched
    import ts_pkg::*;
#(
    parameter string PLATFORM  = "xilinx",
    parameter int    DATA_W    = TS_DATA_W,
    parameter int    MAX_WORDS = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        in_ts_schedule_valid,
    input  logic [3:0]        in_ts_fifo_empty,
    input  logic [DATA_W-1:0] in_ts_q0_data,
    input  logic [DATA_W-1:0] in_ts_q1_data,
    input  logic [DATA_W-1:0] in_ts_q2_data,
    input  logic [DATA_W-1:0] in_ts_q3_data,
    output logic [3:0]        out_ts_q_rden,
    output logic              out_ts_q2_rden,
    input  logic              in_ts_bandwidth_discard,
    output logic [DATA_W-1:0] out_ts_data,
    output logic              out_ts_data_wr,
    output logic              out_ts_pkt_valid,
    output logic              out_ts_err
);

    state_t            state;
    logic [1:0]        sel;
    logic [7:0]        word_cnt;
    logic              q2_pend;
    logic [DATA_W-1:0] head_word;
    logic              pop;
    logic              sop;
    logic              is_tail;
    logic              wd_hit;

    // the vendor selector only matters for vendor primitives, and this block uses none
    if (PLATFORM == "") begin : g_platform_unset
    end

    assign head_word = sel == Q0 ? in_ts_q0_data :
                       sel == Q1 ? in_ts_q1_data :
                       sel == Q2 ? in_ts_q2_data : in_ts_q3_data;

    // pop straight from state so the show-ahead head word leaves the FIFO the cycle it is seen
    assign pop            = state == READ && !in_ts_fifo_empty[sel];
    assign out_ts_q_rden  = pop ? 4'b0001 << sel : 4'b0000;
    assign sop            = pop && word_cnt == 8'd0;
    assign out_ts_q2_rden = sop && sel == Q2;
    assign is_tail        = head_word[DATA_W-1 -: 2] == CODE_TAIL;
    assign wd_hit         = word_cnt == 8'(MAX_WORDS - 1);

    // judge in IDLE, drain the chosen queue in READ, report completion in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            sel              <= Q0;
            word_cnt         <= '0;
            q2_pend          <= 1'b0;
            out_ts_pkt_valid <= 1'b0;
            out_ts_err       <= 1'b0;
        end else begin
            q2_pend          <= out_ts_q2_rden;
            out_ts_pkt_valid <= pop && (is_tail || wd_hit);
            out_ts_err       <= pop && !is_tail && wd_hit;
            case (state)
                IDLE: if (|in_ts_schedule_valid) begin
                    sel   <= prio_sel(in_ts_schedule_valid);
                    state <= READ;
                end
                READ: if (pop) begin
                    word_cnt <= word_cnt + 8'd1;
                    if (is_tail || wd_hit) state <= DONE;
                end
                DONE: begin
                    word_cnt <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    ts_out_pipe #(
        .DATA_W(DATA_W)
    ) u_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .word    (head_word),
        .wr      (pop),
        .sop     (sop),
        .discard (q2_pend & in_ts_bandwidth_discard),
        .data    (out_ts_data),
        .data_wr (out_ts_data_wr)
    );

endmodule

// File: tb/tb_ts_queue_sched.sv
// tb_ts_queue_sched: randomized scheduler bench checked every cycle against a packet-level reference model
`timescale 1ns/1ps
module tb_ts_queue_sched;

    localparam int DW   = 134;
    localparam int MAXW = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    in_ts_schedule_valid = '0;
    logic [3:0]    in_ts_fifo_empty = 4'hf;
    logic [DW-1:0] q_data [4];
    logic          in_ts_bandwidth_discard = 1'b0;
    logic [3:0]    out_ts_q_rden;
    logic          out_ts_q2_rden;
    logic [DW-1:0] out_ts_data;
    logic          out_ts_data_wr;
    logic          out_ts_pkt_valid;
    logic          out_ts_err;

    ts_queue_sched #(
        .PLATFORM  ("xilinx"),
        .DATA_W    (DW),
        .MAX_WORDS (MAXW)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .in_ts_schedule_valid    (in_ts_schedule_valid),
        .in_ts_fifo_empty        (in_ts_fifo_empty),
        .in_ts_q0_data           (q_data[0]),
        .in_ts_q1_data           (q_data[1]),
        .in_ts_q2_data           (q_data[2]),
        .in_ts_q3_data           (q_data[3]),
        .out_ts_q_rden           (out_ts_q_rden),
        .out_ts_q2_rden          (out_ts_q2_rden),
        .in_ts_bandwidth_discard (in_ts_bandwidth_discard),
        .out_ts_data             (out_ts_data),
        .out_ts_data_wr          (out_ts_data_wr),
        .out_ts_pkt_valid        (out_ts_pkt_valid),
        .out_ts_err              (out_ts_err)
    );

    always #5 clk = ~clk;

    // queue contents seen by the scheduler
    logic [DW-1:0] mem [4][256];
    int            rp [4] = '{0, 0, 0, 0};
    int            wp [4] = '{0, 0, 0, 0};

    int total = 0;
    int bad = 0;

    // reference model: which packet is being read, how far, and what must come out two cycles later
    bit            reading = 0;
    bit            exp_pv = 0;
    bit            exp_err = 0;
    bit            prev_q2 = 0;
    bit            want_disc = 0;
    bit            rstall = 0;
    int            sel_m = 0;
    int            cnt = 0;
    int            pid = 0;
    int            stall_at = -1;
    int            stall_left = 0;
    bit            dl_v [2] = '{0, 0};
    logic [DW-1:0] dl_w [2];
    int            dl_p [2] = '{0, 0};
    bit            drop_tbl [256];
    int            pop_tbl [256];
    int            wr_tbl [256];
    int            pv_tbl [256];
    int            q2_tbl [256];
    int            err_tbl [256];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic load(input int q, input int len, input bit tl);
        logic [1:0] code;
        for (int i = 0; i < len; i++) begin
            code = i == 0 ? 2'b01 : (i == len - 1 && tl) ? 2'b10 : 2'b11;
            mem[q][wp[q]] = {code, 4'($urandom), 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
            wp[q]++;
        end
    endtask

    task automatic clear_fifos();
        for (int q = 0; q < 4; q++) begin
            rp[q] = 0;
            wp[q] = 0;
        end
    endtask

    // one clock: drive inputs, compare every output with the model, advance the model
    task automatic step(input logic [3:0] vld);
        logic [3:0]    st;
        logic [3:0]    emp;
        logic [3:0]    exp_rden;
        logic          exp_q2;
        logic          exp_wr;
        logic          idle;
        logic [DW-1:0] w;
        st = '0;
        if (reading && stall_left > 0 && cnt == stall_at) begin
            st[sel_m] = 1'b1;
            stall_left--;
        end else if (reading && rstall && $urandom_range(3) == 0) begin
            st[sel_m] = 1'b1;
        end
        for (int q = 0; q < 4; q++) begin
            emp[q] = (wp[q] == rp[q]) || st[q];
            q_data[q] = (wp[q] != rp[q]) ? mem[q][rp[q]] : '0;
        end
        in_ts_fifo_empty = emp;
        in_ts_schedule_valid = vld;
        in_ts_bandwidth_discard = prev_q2 ? want_disc : 1'($urandom_range(1));
        if (prev_q2 && want_disc) drop_tbl[pid] = 1'b1;
        idle = !reading && !exp_pv;
        exp_rden = (reading && !emp[sel_m]) ? 4'(1 << sel_m) : 4'b0000;
        exp_q2 = exp_rden[2] && cnt == 0;
        exp_wr = dl_v[1] && !drop_tbl[dl_p[1]];
        @(negedge clk);
        chk("rden", int'(out_ts_q_rden), int'(exp_rden));
        chk("q2_rden", int'(out_ts_q2_rden), int'(exp_q2));
        chk("pkt_valid", int'(out_ts_pkt_valid), int'(exp_pv));
        chk("err", int'(out_ts_err), int'(exp_err));
        chk("data_wr", int'(out_ts_data_wr), int'(exp_wr));
        if (exp_wr) chk_d("data", out_ts_data, dl_w[1]);
        pop_tbl[pid] += $countones(out_ts_q_rden);
        q2_tbl[pid]  += int'(out_ts_q2_rden);
        pv_tbl[pid]  += int'(out_ts_pkt_valid);
        err_tbl[pid] += int'(out_ts_err);
        if (out_ts_data_wr) wr_tbl[dl_p[1]]++;
        dl_v[1] = dl_v[0];
        dl_w[1] = dl_w[0];
        dl_p[1] = dl_p[0];
        dl_v[0] = exp_rden != 4'b0000;
        dl_w[0] = '0;
        dl_p[0] = pid;
        exp_pv = 1'b0;
        exp_err = 1'b0;
        if (exp_rden != 4'b0000) begin
            w = mem[sel_m][rp[sel_m]];
            rp[sel_m]++;
            cnt++;
            dl_w[0] = w;
            if (w[DW-1 -: 2] == 2'b10 || cnt == MAXW) begin
                reading = 1'b0;
                exp_pv = 1'b1;
                exp_err = w[DW-1 -: 2] != 2'b10;
            end
        end
        if (idle && vld != 4'b0000) begin
            pid = (pid + 1) % 256;
            drop_tbl[pid] = 1'b0;
            pop_tbl[pid] = 0;
            wr_tbl[pid] = 0;
            pv_tbl[pid] = 0;
            q2_tbl[pid] = 0;
            err_tbl[pid] = 0;
            reading = 1'b1;
            cnt = 0;
            sel_m = 3;
            for (int q = 3; q >= 0; q--) if (vld[q]) sel_m = q;
        end
        prev_q2 = exp_q2;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) step(4'b0000);
    endtask

    // offer one packet to every queue in vld, pulse eligibility, run until the DONE cycle has passed
    task automatic run_pkt(input logic [3:0] vld, input int len, input bit tl, input bit disc,
                           input int s_at, input int s_len, input bit rs, output int id);
        int guard;
        for (int q = 0; q < 4; q++) if (vld[q]) load(q, len, tl);
        want_disc = disc;
        stall_at = s_at;
        stall_left = s_len;
        rstall = rs;
        step(vld);
        id = pid;
        guard = 0;
        while ((reading || exp_pv) && guard < 2000) begin
            step(4'($urandom));
            guard++;
        end
        total++;
        if (reading || exp_pv) begin
            bad++;
            $display("FAIL timeout: packet %0d never completed", id);
        end
        clear_fifos();
    endtask

    initial begin
        int id;
        logic [3:0] v;
        for (int i = 0; i < 256; i++) begin
            drop_tbl[i] = 0;
            pop_tbl[i] = 0;
            wr_tbl[i] = 0;
            pv_tbl[i] = 0;
            q2_tbl[i] = 0;
            err_tbl[i] = 0;
        end
        for (int q = 0; q < 4; q++) q_data[q] = '0;
        dl_w[0] = '0;
        dl_w[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset rden", int'(out_ts_q_rden), 0);
        chk("reset q2_rden", int'(out_ts_q2_rden), 0);
        chk("reset data_wr", int'(out_ts_data_wr), 0);
        chk("reset pkt_valid", int'(out_ts_pkt_valid), 0);
        chk("reset err", int'(out_ts_err), 0);
        chk_d("reset data", out_ts_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_pkt(4'b0001, 4, 1, 0, -1, 0, 0, id);
        idle_cycles(2);
        chk("q0 pops", pop_tbl[id], 4);
        chk("q0 writes", wr_tbl[id], 4);
        chk("q0 pkt_valid", pv_tbl[id], 1);
        chk("q0 q2_rden", q2_tbl[id], 0);

        run_pkt(4'b1110, 3, 1, 0, -1, 0, 0, id);
        idle_cycles(2);
        chk("q1 pops", pop_tbl[id], 3);
        chk("q1 pkt_valid", pv_tbl[id], 1);
        chk("q1 q2_rden", q2_tbl[id], 0);

        run_pkt(4'b0100, 3, 1, 0, -1, 0, 0, id);
        idle_cycles(2);
        chk("q2 keep q2_rden", q2_tbl[id], 1);
        chk("q2 keep writes", wr_tbl[id], 3);

        run_pkt(4'b0100, 3, 1, 1, -1, 0, 0, id);
        idle_cycles(2);
        chk("q2 drop pops", pop_tbl[id], 3);
        chk("q2 drop writes", wr_tbl[id], 0);
        chk("q2 drop pkt_valid", pv_tbl[id], 1);

        run_pkt(4'b1000, 6, 1, 0, 3, 5, 0, id);
        idle_cycles(2);
        chk("q3 stall pops", pop_tbl[id], 6);
        chk("q3 stall writes", wr_tbl[id], 6);
        chk("q3 stall pkt_valid", pv_tbl[id], 1);

        run_pkt(4'b0001, 130, 0, 0, -1, 0, 0, id);
        idle_cycles(2);
        chk("watchdog pops", pop_tbl[id], 128);
        chk("watchdog err", err_tbl[id], 1);
        chk("watchdog pkt_valid", pv_tbl[id], 1);
        chk("watchdog writes", wr_tbl[id], 128);

        run_pkt(4'b1100, 4, 1, 0, -1, 0, 0, id);
        run_pkt(4'b0010, 2, 1, 0, -1, 0, 0, id);
        run_pkt(4'b1000, 3, 1, 0, -1, 0, 1, id);
        idle_cycles(2);
        chk("back-to-back last pops", pop_tbl[id], 3);

        load(1, 5, 1);
        want_disc = 0;
        stall_at = -1;
        stall_left = 0;
        rstall = 0;
        step(4'b0010);
        id = pid;
        step(4'b0000);
        step(4'b0000);
        rst_n = 1'b0;
        #1;
        chk("abort rden", int'(out_ts_q_rden), 0);
        chk("abort data_wr", int'(out_ts_data_wr), 0);
        chk("abort pkt_valid", int'(out_ts_pkt_valid), 0);
        chk_d("abort data", out_ts_data, '0);
        reading = 0;
        exp_pv = 0;
        exp_err = 0;
        prev_q2 = 0;
        dl_v[0] = 0;
        dl_v[1] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle_cycles(5);
        chk("abort pops", pop_tbl[id], 2);
        chk("abort no pkt_valid", pv_tbl[id], 0);
        clear_fifos();

        repeat (40) begin
            v = 4'($urandom_range(1, 15));
            run_pkt(v, $urandom_range(2, 12), 1, 1'($urandom_range(1)),
                    ($urandom_range(3) == 0) ? $urandom_range(0, 3) : -1,
                    $urandom_range(1, 4), 1'($urandom_range(1)), id);
        end
        idle_cycles(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
